// File: rtl/lz77_match_ctrl_pkg.sv
// Shared constants, state encoding and the candidate-window builder used by
// the LZ77 match sequencer.
package lz77_pkg;

    localparam int SB_DEPTH  = 9;
    localparam int LA_DEPTH  = 8;
    localparam int CMP_BYTES = 7;
    localparam int OFF_W     = 4;
    localparam int CMP_W     = CMP_BYTES * 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Byte k of the candidate: sb[off-k] while inside the search buffer,
    // otherwise it runs on into the lookahead (overlapping match).
    function automatic logic [CMP_W-1:0] build_cand(
        input logic [SB_DEPTH*8-1:0] sb,
        input logic [LA_DEPTH*8-1:0] la,
        input logic [OFF_W-1:0]      off
    );
        logic [CMP_W-1:0] cand;
        int               j;
        cand = '0;
        for (int k = 0; k < CMP_BYTES; k++) begin
            j = int'(off) - k;
            if (j >= 0 && j < SB_DEPTH)
                cand[(CMP_BYTES-1-k)*8 +: 8] = sb[j*8 +: 8];
            else if (j < 0)
                cand[(CMP_BYTES-1-k)*8 +: 8] = la[(-j-1)*8 +: 8];
        end
        return cand;
    endfunction

endpackage

// File: rtl/lz77_match_ctrl_if.sv
// Request/result bundle between the encoder top-level FSM (master) and the
// match sequencer (slave).
interface lz77_match_ctrl_if;
    import lz77_pkg::*;

    logic                    start;
    logic [SB_DEPTH*8-1:0]   sb_data;
    logic [OFF_W-1:0]        sb_cnt;
    logic [LA_DEPTH*8-1:0]   la_data;
    logic [3:0]              la_cnt;
    logic                    busy;
    logic                    done;
    logic [OFF_W-1:0]        match_off;
    logic [2:0]              match_len;
    logic [7:0]              next_char;
    logic                    eos;

    modport master (
        output start, sb_data, sb_cnt, la_data, la_cnt,
        input  busy, done, match_off, match_len, next_char, eos
    );

    modport slave (
        input  start, sb_data, sb_cnt, la_data, la_cnt,
        output busy, done, match_off, match_len, next_char, eos
    );

endinterface

// File: rtl/lz77_match_ctrl_cmp.sv
// 7-byte prefix comparator: counts equal bytes starting from the MSB byte.
module cmp
    import lz77_pkg::*;
(
    input  logic [CMP_W-1:0] buff1,
    input  logic [CMP_W-1:0] buff2,
    output logic [2:0]       len
);

    logic stop;

    always_comb begin
        len  = 3'd0;
        stop = 1'b0;
        for (int k = 0; k < CMP_BYTES; k++) begin
            if (!stop && buff1[(CMP_BYTES-1-k)*8 +: 8] == buff2[(CMP_BYTES-1-k)*8 +: 8])
                len = len + 3'd1;
            else
                stop = 1'b1;
        end
    end

endmodule

// File: rtl/lz77_match_ctrl.sv
// LZ77 match sequencer: sweeps one search offset per cycle through a single
// comparator and returns the longest (offset, length, next_char) triple.
module lz77_match_ctrl
    import lz77_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    lz77_match_ctrl_if.slave  bus
);

    // state | meaning
    // IDLE  | waiting for start, last result held on the outputs
    // SCAN  | one search offset compared per cycle
    // FIN   | done pulse, result outputs freshly loaded
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] SCAN = ST_SCAN;
    localparam logic [1:0] FIN  = ST_FIN;

    logic [1:0]             state;
    logic [SB_DEPTH*8-1:0]  sb_q;
    logic [LA_DEPTH*8-1:0]  la_q;
    logic [OFF_W-1:0]       sb_cnt_q;
    logic [2:0]             lim;
    logic [2:0]             best_len;
    logic [OFF_W-1:0]       best_off;
    logic [OFF_W-1:0]       off;
    logic [OFF_W-1:0]       match_off_q;
    logic [2:0]             match_len_q;
    logic [7:0]             next_char_q;
    logic                   eos_q;

    logic [CMP_W-1:0]       la_word;
    logic [CMP_W-1:0]       cand;
    logic [2:0]             cmp_len;
    logic [2:0]             clen;
    logic                   upd;
    logic [2:0]             new_best_len;
    logic [OFF_W-1:0]       new_best_off;
    logic                   scan_end;
    logic [2:0]             start_lim;

    always_comb begin
        la_word = '0;
        for (int k = 0; k < CMP_BYTES; k++)
            la_word[(CMP_BYTES-1-k)*8 +: 8] = la_q[k*8 +: 8];
    end

    assign cand = build_cand(sb_q, la_q, off);

    cmp u_cmp (
        .buff1 (la_word),
        .buff2 (cand),
        .len   (cmp_len)
    );

    assign clen         = (cmp_len > lim) ? lim : cmp_len;
    assign upd          = (off < sb_cnt_q) && (clen > best_len);
    assign new_best_len = upd ? clen : best_len;
    assign new_best_off = upd ? off : best_off;
    assign scan_end     = (new_best_len == lim) || (off == OFF_W'(SB_DEPTH-1));

    // Only la_cnt-1 bytes may be matched so that next_char always exists.
    always_comb begin
        if (bus.la_cnt == 4'd0)
            start_lim = 3'd0;
        else if (bus.la_cnt >= 4'd8)
            start_lim = 3'd7;
        else
            start_lim = 3'(bus.la_cnt - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sb_q        <= '0;
            la_q        <= '0;
            sb_cnt_q    <= '0;
            lim         <= '0;
            best_len    <= '0;
            best_off    <= '0;
            off         <= '0;
            match_off_q <= '0;
            match_len_q <= '0;
            next_char_q <= '0;
            eos_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sb_q     <= bus.sb_data;
                        la_q     <= bus.la_data;
                        sb_cnt_q <= bus.sb_cnt;
                        lim      <= start_lim;
                        best_len <= '0;
                        best_off <= '0;
                        off      <= '0;
                        if (bus.la_cnt == 4'd0) begin
                            state       <= FIN;
                            match_off_q <= '0;
                            match_len_q <= '0;
                            next_char_q <= bus.la_data[7:0];
                            eos_q       <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    best_len <= new_best_len;
                    best_off <= new_best_off;
                    // Result registers load on the way into FIN so they are
                    // already valid while done is high.
                    if (scan_end) begin
                        state       <= FIN;
                        match_off_q <= new_best_off;
                        match_len_q <= new_best_len;
                        next_char_q <= la_q[{new_best_len, 3'b000} +: 8];
                        eos_q       <= 1'b0;
                    end else begin
                        off <= off + OFF_W'(1);
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == SCAN);
    assign bus.done      = (state == FIN);
    assign bus.match_off = match_off_q;
    assign bus.match_len = match_len_q;
    assign bus.next_char = next_char_q;
    assign bus.eos       = eos_q;

endmodule

// File: tb/tb_lz77_match_ctrl.sv
// Bench for lz77_match_ctrl: directed jobs with literal expectations plus a
// per-cycle comparison against a string-level LZ77 longest-match model.
module tb_lz77_match_ctrl;
    import lz77_pkg::*;

    typedef struct packed {
        int off;
        int len;
        int nc;
        int eos;
        int n;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lz77_match_ctrl_if bus ();

    lz77_match_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Window w = search buffer oldest..newest followed by the lookahead;
    // offset j starts the candidate string at w[8-j].
    function automatic res_t model_run(input logic [71:0] sb, input int sbc,
                                       input logic [63:0] la, input int lac);
        res_t r;
        logic [7:0] w [17];
        logic [7:0] lb [8];
        int lim, best, bo, len, p;
        r = '0;
        for (int i = 0; i < 8; i++) lb[i] = la[8*i +: 8];
        if (lac == 0) begin
            r.nc  = int'(lb[0]);
            r.eos = 1;
            return r;
        end
        lim = (lac - 1 > 7) ? 7 : lac - 1;
        for (int i = 0; i < 17; i++) w[i] = (i < 9) ? sb[8*(8-i) +: 8] : lb[i-9];
        best = 0;
        bo   = 0;
        for (int j = 0; j < 9; j++) begin
            r.n = j + 1;
            p   = 8 - j;
            len = 0;
            while (len < lim && w[p+len] == lb[len]) len++;
            if (j < sbc && len > best) begin
                best = len;
                bo   = j;
            end
            if (best == lim) break;
        end
        r.off = bo;
        r.len = best;
        r.nc  = int'(lb[best]);
        return r;
    endfunction

    // Model timing: edge e samples start; done is visible after edge e+n.
    int   e = 0;
    logic armed = 1'b0;
    logic job = 1'b0;
    int   st = 0, dn = 0;
    res_t r_res = '0;
    res_t x_res = '0;

    always @(posedge clk) begin
        e <= e + 1;
        if (reset) begin
            job   <= 1'b0;
            x_res <= '0;
            armed <= 1'b1;
        end else if (armed) begin
            if (bus.start && (!job || e + 1 >= dn + 2)) begin
                job   <= 1'b1;
                st    <= e + 1;
                dn    <= e + 1 + model_run(bus.sb_data, int'(bus.sb_cnt), bus.la_data, int'(bus.la_cnt)).n;
                r_res <= model_run(bus.sb_data, int'(bus.sb_cnt), bus.la_data, int'(bus.la_cnt));
                if (model_run(bus.sb_data, int'(bus.sb_cnt), bus.la_data, int'(bus.la_cnt)).n == 0)
                    x_res <= model_run(bus.sb_data, int'(bus.sb_cnt), bus.la_data, int'(bus.la_cnt));
            end else if (job && e + 1 == dn) begin
                x_res <= r_res;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("done",      int'(bus.done),      int'(job && e == dn));
            chk("busy",      int'(bus.busy),      int'(job && e >= st && e < dn));
            chk("match_off", int'(bus.match_off), x_res.off);
            chk("match_len", int'(bus.match_len), x_res.len);
            chk("next_char", int'(bus.next_char), x_res.nc);
            chk("eos",       int'(bus.eos),       x_res.eos);
        end
    end

    function automatic logic [63:0] pack_la(input string s);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < s.len() && i < 8; i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    task automatic run_job(input string tag, input logic [71:0] sb, input int sbc,
                           input logic [63:0] la, input int lac,
                           input int x_off, input int x_len, input int x_nc,
                           input int x_eos, input int x_cyc);
        int cyc;
        @(negedge clk);
        bus.sb_data = sb;
        bus.sb_cnt  = OFF_W'(sbc);
        bus.la_data = la;
        bus.la_cnt  = 4'(lac);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_cycle"}, cyc, x_cyc);
        chk({tag, "_off"},   int'(bus.match_off), x_off);
        chk({tag, "_len"},   int'(bus.match_len), x_len);
        chk({tag, "_nc"},    int'(bus.next_char), x_nc);
        chk({tag, "_eos"},   int'(bus.eos),       x_eos);
    endtask

    logic [71:0] sb_abc, sb_tie, sb_far;
    res_t        pin;
    int          done_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.sb_data = '0;
        bus.sb_cnt  = '0;
        bus.la_data = '0;
        bus.la_cnt  = '0;

        sb_abc = '0; sb_abc[8*2 +: 8] = "A"; sb_abc[8*1 +: 8] = "B"; sb_abc[8*0 +: 8] = "C";
        sb_tie = '0; sb_tie[8*1 +: 8] = "A"; sb_tie[8*4 +: 8] = "A";
        sb_far = '0; sb_far[8*5 +: 8] = "A"; sb_far[8*4 +: 8] = "B"; sb_far[8*3 +: 8] = "C";

        pin = model_run(sb_abc, 9, pack_la("ABCABCAB"), 8);
        chk("model_overlap_n",   pin.n,   3);
        chk("model_overlap_len", pin.len, 7);
        pin = model_run(sb_tie, 9, pack_la("AZZZZZZZ"), 8);
        chk("model_tie_off",     pin.off, 1);
        pin = model_run(sb_far, 2, pack_la("ABC"), 8);
        chk("model_inelig_len",  pin.len, 0);

        repeat (3) @(negedge clk);
        reset = 1'b0;

        run_job("sweep",    '0,     9, pack_la("xyzwvuts"), 8, 0, 0, 8'h78, 0, 10);
        run_job("overlap",  sb_abc, 9, pack_la("ABCABCAB"), 8, 2, 7, 8'h42, 0, 4);
        run_job("tie",      sb_tie, 9, pack_la("AZZZZZZZ"), 8, 1, 1, 8'h5A, 0, 10);
        run_job("lim2",     sb_abc, 9, pack_la("ABCABCAB"), 3, 2, 2, 8'h43, 0, 4);
        run_job("inelig",   sb_far, 2, pack_la("ABC"),      8, 0, 0, 8'h41, 0, 10);
        run_job("lim0",     sb_abc, 9, pack_la("ABCABCAB"), 1, 0, 0, 8'h41, 0, 2);
        run_job("sbcnt0",   sb_abc, 0, pack_la("ABCABCAB"), 8, 0, 0, 8'h41, 0, 10);
        run_job("eos",      sb_abc, 9, pack_la("QRS"),      0, 0, 0, 8'h51, 1, 1);

        // Reset mid-scan with stray start pulses while busy.
        @(negedge clk);
        bus.sb_data = '0;
        bus.sb_cnt  = OFF_W'(9);
        bus.la_data = pack_la("xyzwvuts");
        bus.la_cnt  = 4'd8;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_off", int'(bus.match_off), 0);
        chk("rst_len", int'(bus.match_len), 0);
        chk("rst_nc",  int'(bus.next_char), 0);
        done_seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        chk("rst_no_done", done_seen, 0);

        run_job("after_rst", sb_abc, 9, pack_la("ABCABCAB"), 8, 2, 7, 8'h42, 0, 4);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
